// File: rtl/metaballs_pkg.sv
// Shared types, widths and default geometry for the metaball motion engine.
// Also holds the velocity step helper used by the shared per-axis adder.
package metaballs_pkg;
    localparam int COORD_W           = 10;
    localparam int VEL_W             = 10;
    localparam int DEF_SCREEN_WIDTH  = 800;
    localparam int DEF_SCREEN_HEIGHT = 600;
    localparam int DEF_BALL_SIZE     = 128;
    localparam int DEF_VEL_MAX       = 127;

    typedef enum logic [1:0] {IDLE, POS, VEL, COMMIT} state_t;
    typedef logic [COORD_W-1:0]        coord_t;
    typedef logic signed [VEL_W-1:0]   vel_t;

    // One spring step toward the centre, saturating at +/-vmax; zero after a wall hit.
    function automatic vel_t vel_update(vel_t v, logic up, logic zero, vel_t vmax);
        logic signed [VEL_W:0] one;
        logic signed [VEL_W:0] ext;
        logic signed [VEL_W:0] lim;
        logic signed [VEL_W:0] s;
        vel_t                  res;
        one = (VEL_W+1)'(1);
        ext = (VEL_W+1)'(v);
        lim = (VEL_W+1)'(vmax);
        s   = up ? ext + one : ext - one;
        res = s[VEL_W-1:0];
        if (s > lim)
            res = vmax;
        else if (s < -lim)
            res = -vmax;
        if (zero)
            res = '0;
        return res;
    endfunction
endpackage

// File: rtl/ball_motion_if.sv
// Frame sync input and committed ball positions toward the renderers.
interface ball_motion_if;
    logic                    v_sync;
    metaballs_pkg::coord_t   ball0_x;
    metaballs_pkg::coord_t   ball0_y;
    metaballs_pkg::coord_t   ball1_x;
    metaballs_pkg::coord_t   ball1_y;
    logic                    frame_tick;
    logic                    busy;

    modport master (
        input  v_sync,
        output ball0_x, ball0_y, ball1_x, ball1_y, frame_tick, busy
    );
    modport slave (
        output v_sync,
        input  ball0_x, ball0_y, ball1_x, ball1_y, frame_tick, busy
    );
endinterface

// File: rtl/ball_step.sv
// Combinational single-axis position step: pos + (vel >>> 2), clamped to [0, limit].
module ball_step
    import metaballs_pkg::*;
(
    input  coord_t pos,
    input  vel_t   vel,
    input  coord_t limit,
    output coord_t next_pos,
    output logic   clamped
);
    localparam int SW = COORD_W + 1;

    vel_t              delta;
    logic [SW-1:0]     sum;

    always_comb begin
        delta    = vel >>> 2;
        sum      = {1'b0, pos} + SW'(delta);
        next_pos = sum[COORD_W-1:0];
        clamped  = 1'b0;
        if (sum[SW-1]) begin
            next_pos = '0;
            clamped  = 1'b1;
        end else if (sum[COORD_W-1:0] > limit) begin
            next_pos = limit;
            clamped  = 1'b1;
        end
    end
endmodule

// File: rtl/ball_motion.sv
// Per-frame metaball motion: on v_sync rise, steps both balls serially, commits all at once.
// Edge at cycle k -> busy k+1..k+5, new positions and frame_tick at k+6; edges while busy are dropped.
module ball_motion
    import metaballs_pkg::*;
#(
    parameter int SCREEN_WIDTH  = DEF_SCREEN_WIDTH,
    parameter int SCREEN_HEIGHT = DEF_SCREEN_HEIGHT,
    parameter int BALL_SIZE     = DEF_BALL_SIZE,
    parameter int VEL_MAX       = DEF_VEL_MAX,
    parameter int START_X0      = 224,
    parameter int START_Y0      = 157,
    parameter int START_X1      = 425,
    parameter int START_Y1      = 188,
    parameter int START_VX0     = 0,
    parameter int START_VY0     = 0,
    parameter int START_VX1     = 0,
    parameter int START_VY1     = 0
) (
    input  logic           clk_50mhz,
    input  logic           reset,
    ball_motion_if.master  bus
);
    localparam coord_t XLIM = coord_t'(SCREEN_WIDTH - BALL_SIZE);
    localparam coord_t YLIM = coord_t'(SCREEN_HEIGHT - BALL_SIZE);
    localparam coord_t XMID = coord_t'((SCREEN_WIDTH - BALL_SIZE) / 2);
    localparam coord_t YMID = coord_t'((SCREEN_HEIGHT - BALL_SIZE) / 2);
    localparam vel_t   VMAX = vel_t'(VEL_MAX);

    state_t  state;
    logic    idx;
    logic    v_sync_d;
    logic    vs_rise;
    logic    tick_q;
    logic    busy_q;
    logic    clamp_x;
    logic    clamp_y;
    coord_t  out_x [2];
    coord_t  out_y [2];
    coord_t  sh_x  [2];
    coord_t  sh_y  [2];
    vel_t    vx    [2];
    vel_t    vy    [2];

    coord_t  nx;
    coord_t  ny;
    logic    cx;
    logic    cy;
    vel_t    vx_next;
    vel_t    vy_next;

    assign vs_rise = bus.v_sync & ~v_sync_d;

    ball_step u_step_x (.pos(out_x[idx]), .vel(vx[idx]), .limit(XLIM), .next_pos(nx), .clamped(cx));
    ball_step u_step_y (.pos(out_y[idx]), .vel(vy[idx]), .limit(YLIM), .next_pos(ny), .clamped(cy));

    // One velocity adder per axis, shared across both balls through idx.
    always_comb begin
        vx_next = vel_update(vx[idx], sh_x[idx] < XMID, clamp_x, VMAX);
        vy_next = vel_update(vy[idx], sh_y[idx] < YMID, clamp_y, VMAX);
    end

    always_ff @(posedge clk_50mhz) begin
        if (reset) begin
            state    <= IDLE;
            idx      <= 1'b0;
            v_sync_d <= 1'b1;
            tick_q   <= 1'b0;
            busy_q   <= 1'b0;
            clamp_x  <= 1'b0;
            clamp_y  <= 1'b0;
            out_x[0] <= coord_t'(START_X0);
            out_y[0] <= coord_t'(START_Y0);
            out_x[1] <= coord_t'(START_X1);
            out_y[1] <= coord_t'(START_Y1);
            sh_x[0]  <= coord_t'(START_X0);
            sh_y[0]  <= coord_t'(START_Y0);
            sh_x[1]  <= coord_t'(START_X1);
            sh_y[1]  <= coord_t'(START_Y1);
            vx[0]    <= vel_t'(START_VX0);
            vy[0]    <= vel_t'(START_VY0);
            vx[1]    <= vel_t'(START_VX1);
            vy[1]    <= vel_t'(START_VY1);
        end else begin
            v_sync_d <= bus.v_sync;
            tick_q   <= 1'b0;
            case (state)
                IDLE: begin
                    if (vs_rise) begin
                        state  <= POS;
                        idx    <= 1'b0;
                        busy_q <= 1'b1;
                    end
                end
                POS: begin
                    sh_x[idx] <= nx;
                    sh_y[idx] <= ny;
                    clamp_x   <= cx;
                    clamp_y   <= cy;
                    state     <= VEL;
                end
                VEL: begin
                    vx[idx] <= vx_next;
                    vy[idx] <= vy_next;
                    if (idx) begin
                        state <= COMMIT;
                    end else begin
                        idx   <= 1'b1;
                        state <= POS;
                    end
                end
                COMMIT: begin
                    out_x  <= sh_x;
                    out_y  <= sh_y;
                    tick_q <= 1'b1;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ball0_x    = out_x[0];
    assign bus.ball0_y    = out_y[0];
    assign bus.ball1_x    = out_x[1];
    assign bus.ball1_y    = out_y[1];
    assign bus.frame_tick = tick_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_ball_motion.sv
// Bench for ball_motion: two instances (default and wall/saturation-stressing overrides) against an integer model.
module tb_ball_motion;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic v_sync = 1'b1;

    always #5 clk = ~clk;

    ball_motion_if ia ();
    ball_motion_if ib ();
    assign ia.v_sync = v_sync;
    assign ib.v_sync = v_sync;

    ball_motion dut_a (.clk_50mhz(clk), .reset(rst), .bus(ia));
    ball_motion #(.START_X0(0), .START_VX0(-8), .VEL_MAX(20)) dut_b (.clk_50mhz(clk), .reset(rst), .bus(ib));

    localparam int LIM_X = 672;
    localparam int LIM_Y = 472;

    int nvec = 0;
    int nmis = 0;

    // Model state indexed [instance][ball].
    int m_x [2][2];
    int m_y [2][2];
    int m_vx[2][2];
    int m_vy[2][2];
    int vmax[2] = '{127, 20};

    int cyc = 0;
    int commit_at = 0;
    int ready_at = 0;
    bit pending = 0;
    bit prev_v = 1;
    bit exp_tick = 0;

    function automatic int shr2(int v);
        return (v < 0) ? -((-v + 3) / 4) : v / 4;
    endfunction

    task automatic axis(input int p, input int v, input int lim, input int vm, output int np, output int nv);
        int n;
        n = p + shr2(v);
        if (n < 0 || n > lim) begin
            np = (n < 0) ? 0 : lim;
            nv = 0;
        end else begin
            np = n;
            nv = v + ((n < lim / 2) ? 1 : -1);
            if (nv > vm) nv = vm;
            if (nv < -vm) nv = -vm;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_x[i][0] = (i == 1) ? 0 : 224;  m_y[i][0] = 157;
            m_x[i][1] = 425;                 m_y[i][1] = 188;
            m_vx[i][0] = (i == 1) ? -8 : 0;  m_vy[i][0] = 0;
            m_vx[i][1] = 0;                  m_vy[i][1] = 0;
        end
    endtask

    task automatic model_frame();
        int np, nv;
        for (int i = 0; i < 2; i++)
            for (int b = 0; b < 2; b++) begin
                axis(m_x[i][b], m_vx[i][b], LIM_X, vmax[i], np, nv);
                m_x[i][b] = np; m_vx[i][b] = nv;
                axis(m_y[i][b], m_vy[i][b], LIM_Y, vmax[i], np, nv);
                m_y[i][b] = np; m_vy[i][b] = nv;
            end
    endtask

    function automatic logic [83:0] exp_vec();
        return {10'(m_x[0][0]), 10'(m_y[0][0]), 10'(m_x[0][1]), 10'(m_y[0][1]), exp_tick, pending,
                10'(m_x[1][0]), 10'(m_y[1][0]), 10'(m_x[1][1]), 10'(m_y[1][1]), exp_tick, pending};
    endfunction

    function automatic logic [83:0] obs_vec();
        return {ia.ball0_x, ia.ball0_y, ia.ball1_x, ia.ball1_y, ia.frame_tick, ia.busy,
                ib.ball0_x, ib.ball0_y, ib.ball1_x, ib.ball1_y, ib.frame_tick, ib.busy};
    endfunction

    // Drives one cycle of v_sync and advances the model; outputs are then sampled 1 ns after the edge.
    task automatic step(input bit v);
        v_sync = v;
        @(posedge clk);
        #1;
        exp_tick = 0;
        if (v && !prev_v && cyc >= ready_at) begin
            pending   = 1;
            commit_at = cyc + 5;
            ready_at  = cyc + 6;
        end
        if (pending && cyc == commit_at) begin
            model_frame();
            pending  = 0;
            exp_tick = 1;
        end
        prev_v = v;
        cyc++;
    endtask

    task automatic apply_reset(input int n);
        rst = 1'b1;
        v_sync = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        pending = 0;
        prev_v = 1;
        exp_tick = 0;
        ready_at = 0;
        cyc += n;
    endtask

    task automatic test_reset();
        apply_reset(3);
        nvec++;
        if ({ia.ball0_x, ia.ball0_y, ia.ball1_x, ia.ball1_y, ia.frame_tick, ia.busy} !== {10'd224, 10'd157, 10'd425, 10'd188, 2'b00}) begin
            nmis++;
            $display("FAIL reset_state got=%h exp=%h", {ia.ball0_x, ia.ball0_y, ia.ball1_x, ia.ball1_y, ia.frame_tick, ia.busy},
                     {10'd224, 10'd157, 10'd425, 10'd188, 2'b00});
        end
        nvec++;
        if (obs_vec() !== exp_vec()) begin
            nmis++; $display("FAIL reset_model got=%h exp=%h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_idle_hold();
        for (int c = 0; c < 10000; c++) begin
            step(1);
            nvec++;
            if (obs_vec() !== exp_vec()) begin
                nmis++; $display("FAIL idle_hold cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_single_frame();
        step(0);
        for (int j = 1; j <= 7; j++) begin
            step(1);
            nvec++;
            if ({ia.busy, ia.frame_tick} !== {(j <= 5), (j == 6)}) begin
                nmis++; $display("FAIL frame_timing k+%0d got=%b exp=%b", j, {ia.busy, ia.frame_tick}, {(j <= 5), (j == 6)});
            end
            nvec++;
            if (obs_vec() !== exp_vec()) begin
                nmis++; $display("FAIL single_frame k+%0d got=%h exp=%h", j, obs_vec(), exp_vec());
            end
        end
        nvec++;
        if (ia.ball0_x !== 10'd224) begin
            nmis++; $display("FAIL first_frame_x0 got=%0d exp=224", ia.ball0_x);
        end
    endtask

    task automatic test_five_frames();
        for (int f = 0; f < 4; f++) begin
            step(0);
            for (int j = 0; j < 8; j++) begin
                step(1);
                nvec++;
                if (obs_vec() !== exp_vec()) begin
                    nmis++; $display("FAIL five_frames cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
                end
            end
        end
        nvec++;
        if (ia.ball0_x !== 10'd225) begin
            nmis++; $display("FAIL five_frames_x0 got=%0d exp=225", ia.ball0_x);
        end
    endtask

    task automatic test_ball1_shift();
        apply_reset(2);
        for (int f = 0; f < 2; f++) begin
            step(0);
            for (int j = 0; j < 7; j++) begin
                step(1);
                nvec++;
                if (obs_vec() !== exp_vec()) begin
                    nmis++; $display("FAIL ball1_shift cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
                end
            end
        end
        nvec++;
        if (ia.ball1_x !== 10'd424) begin
            nmis++; $display("FAIL ball1_x_shift got=%0d exp=424", ia.ball1_x);
        end
    endtask

    task automatic test_back_to_back();
        bit pat[28];
        int ticks;
        for (int j = 0; j < 28; j++) pat[j] = (j == 0 || j == 3 || j >= 20);
        apply_reset(2);
        step(0);
        ticks = 0;
        for (int j = 0; j < 28; j++) begin
            step(pat[j]);
            ticks += ia.frame_tick;
            nvec++;
            if (obs_vec() !== exp_vec()) begin
                nmis++; $display("FAIL back_to_back k+%0d got=%h exp=%h", j, obs_vec(), exp_vec());
            end
            if (j == 19) begin
                nvec++;
                if (ticks !== 1) begin
                    nmis++; $display("FAIL busy_edge_ignored ticks=%0d exp=1", ticks);
                end
            end
        end
        nvec++;
        if (ticks !== 2) begin
            nmis++; $display("FAIL edge_after_idle ticks=%0d exp=2", ticks);
        end
    endtask

    task automatic test_clamp_and_reset();
        apply_reset(2);
        for (int f = 0; f < 10; f++) begin
            step(0);
            for (int j = 0; j < 6; j++) begin
                step(1);
                nvec++;
                if (obs_vec() !== exp_vec()) begin
                    nmis++; $display("FAIL clamp_frames cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
                end
            end
            if (f == 0) begin
                nvec++;
                if (ib.ball0_x !== 10'd0) begin
                    nmis++; $display("FAIL clamp_low_x0 got=%0d exp=0", ib.ball0_x);
                end
            end
        end
        step(0);
        step(1);
        step(1);
        step(1);
        apply_reset(1);
        nvec++;
        if ({ia.ball0_x, ia.ball0_y, ia.ball1_x, ia.ball1_y, ib.ball0_x, ia.busy, ia.frame_tick} !==
            {10'd224, 10'd157, 10'd425, 10'd188, 10'd0, 2'b00}) begin
            nmis++;
            $display("FAIL midupdate_reset got=%h exp=%h", {ia.ball0_x, ia.ball0_y, ia.ball1_x, ia.ball1_y, ib.ball0_x, ia.busy, ia.frame_tick},
                     {10'd224, 10'd157, 10'd425, 10'd188, 10'd0, 2'b00});
        end
    endtask

    task automatic test_random_frames();
        int lo, hi;
        bit ok;
        for (int f = 0; f < 3000; f++) begin
            lo = $urandom_range(3, 1);
            hi = $urandom_range(8, 1);
            for (int j = 0; j < lo + hi; j++) begin
                step(j >= lo);
                nvec++;
                if (obs_vec() !== exp_vec()) begin
                    nmis++; $display("FAIL random_frames cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
                end
                ok = (ia.ball0_x <= LIM_X) && (ia.ball1_x <= LIM_X) && (ia.ball0_y <= LIM_Y) && (ia.ball1_y <= LIM_Y) &&
                     (ib.ball0_x <= LIM_X) && (ib.ball1_x <= LIM_X) && (ib.ball0_y <= LIM_Y) && (ib.ball1_y <= LIM_Y);
                nvec++;
                if (!ok) begin
                    nmis++; $display("FAIL range cyc=%0d got=%h", cyc, obs_vec());
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle_hold();
        test_single_frame();
        test_five_frames();
        test_ball1_shift();
        test_back_to_back();
        test_clamp_and_reset();
        test_random_frames();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
